// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Request/response and memory-side bundle for dmem_ctrl.
//               slave  = controller view, master = requesters + memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // Requester side, port n packed at index n
    logic [1:0]              req;
    logic [1:0]              gnt;
    logic [1:0]              p_we;
    logic [3:0]              p_size;
    logic [1:0]              p_unsigned;
    logic [2*ADDR_WIDTH-1:0] p_addr;
    logic [2*DATA_WIDTH-1:0] p_wdata;

    // Response side
    logic                    rsp_valid;
    logic                    rsp_id;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    busy;

    // Data-memory side
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wr_data;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    modport slave (
        input  req, p_we, p_size, p_unsigned, p_addr, p_wdata, mem_rd_data,
        output gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata, busy,
               mem_wr_en, mem_addr, mem_wr_data
    );

    modport master (
        output req, p_we, p_size, p_unsigned, p_addr, p_wdata, mem_rd_data,
        input  gnt, rsp_valid, rsp_id, rsp_err, rsp_rdata, busy,
               mem_wr_en, mem_addr, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Two-port arbiter and access sequencer for the byte-addressed,
//               word-wide data memory. Byte/half/word loads and stores become
//               aligned word accesses; sub-word stores use read-modify-write.
//               Load data is returned sign- or zero-extended.
// Options     : DMEM_CTRL_FIXED_PRIO_EN - port 0 always wins simultaneous
//               requests (default: round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  wire logic   clk,
    input  wire logic   reset,
    dmem_ctrl_if.slave  bus
);

    localparam logic [31:0] c_depth = 32'(DEPTH);
    localparam logic [1:0]  c_byte  = 2'b00;
    localparam logic [1:0]  c_half  = 2'b01;
    localparam logic [1:0]  c_word  = 2'b10;
    localparam logic [1:0]  c_bad   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Latched transaction
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_id;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;

    // Winner selection and its request fields
    logic                    w_win;
    logic                    w_sel_we;
    logic [1:0]              w_sel_size;
    logic                    w_sel_unsigned;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_err;
    logic                    w_accept;

    logic [1:0]              w_gnt;
    logic                    w_mem_wr_en;
    logic [DATA_WIDTH-1:0]   w_mem_wr_data;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [7:0]              w_lane8;
    logic [15:0]             w_lane16;
    logic [DATA_WIDTH-1:0]   w_load;

`ifdef DMEM_CTRL_FIXED_PRIO_EN
    // Port 0 wins whenever it requests
    always_comb begin
        w_win = ~bus.req[0];
    end
`else
    logic                    r_last;

    // Round-robin: on a tie the port not granted last wins
    always_comb begin
        w_win = bus.req[1];
        if (bus.req == 2'b11) begin
            w_win = ~r_last;
        end
    end

    // Last-grant pointer; reset to 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`endif

    // Mux the winning port's fields and check legality before acceptance
    always_comb begin
        w_sel_we       = w_win ? bus.p_we[1]       : bus.p_we[0];
        w_sel_size     = w_win ? bus.p_size[3:2]   : bus.p_size[1:0];
        w_sel_unsigned = w_win ? bus.p_unsigned[1] : bus.p_unsigned[0];
        w_sel_addr     = w_win ? bus.p_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : bus.p_addr[ADDR_WIDTH-1:0];
        w_sel_wdata    = w_win ? bus.p_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : bus.p_wdata[DATA_WIDTH-1:0];
        w_sel_err      = (w_sel_size == c_bad)
                       || ((w_sel_size == c_half) && w_sel_addr[0])
                       || ((w_sel_size == c_word) && (w_sel_addr[1:0] != 2'b00))
                       || ({{(32-ADDR_WIDTH){1'b0}}, w_sel_addr} >= c_depth);
        w_accept       = (r_state == S_IDLE) && (|bus.req) && !reset;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant and memory write strobes; reset forces all quiet
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt         = 2'b00;
        w_mem_wr_en   = 1'b0;
        w_mem_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_gnt       = w_win ? 2'b10 : 2'b01;
                    w_state_nxt = w_sel_err ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_we && (r_size == c_word)) begin
                    w_mem_wr_en   = 1'b1;
                    w_mem_wr_data = r_wdata;
                    w_state_nxt   = S_DONE;
                end else if (r_we) begin
                    w_state_nxt   = S_MERGE;
                end else begin
                    w_state_nxt   = S_DONE;
                end
            end
            S_MERGE: begin
                w_mem_wr_en   = 1'b1;
                w_mem_wr_data = w_merged;
                w_state_nxt   = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (reset) begin
            w_gnt         = 2'b00;
            w_mem_wr_en   = 1'b0;
            w_mem_wr_data = '0;
        end
    end

    // Latch the accepted request and capture memory read data after ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_id       <= 1'b0;
            r_err      <= 1'b0;
            r_word     <= '0;
            r_mem_addr <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= w_sel_we;
                r_size     <= w_sel_size;
                r_unsigned <= w_sel_unsigned;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_id       <= w_win;
                r_err      <= w_sel_err;
                if (!w_sel_err) begin
                    r_mem_addr <= {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            if ((r_state == S_ACCESS) && !(r_we && (r_size == c_word))) begin
                r_word <= bus.mem_rd_data;
            end
        end
    end

    // Replace the addressed byte or half lane of the captured word
    always_comb begin
        w_merged = r_word;
        if (r_size == c_byte) begin
            case (r_addr[1:0])
                2'b00:   w_merged = {r_word[31:8],  r_wdata[7:0]};
                2'b01:   w_merged = {r_word[31:16], r_wdata[7:0], r_word[7:0]};
                2'b10:   w_merged = {r_word[31:24], r_wdata[7:0], r_word[15:0]};
                default: w_merged = {r_wdata[7:0],  r_word[23:0]};
            endcase
        end else if (r_size == c_half) begin
            w_merged = r_addr[1] ? {r_wdata[15:0], r_word[15:0]}
                                 : {r_word[31:16], r_wdata[15:0]};
        end
    end

    // Little-endian lane select and sign/zero extension of load data
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_lane8 = r_word[7:0];
            2'b01:   w_lane8 = r_word[15:8];
            2'b10:   w_lane8 = r_word[23:16];
            default: w_lane8 = r_word[31:24];
        endcase
        w_lane16 = r_addr[1] ? r_word[31:16] : r_word[15:0];
        case (r_size)
            c_byte:  w_load = r_unsigned ? {24'h0, w_lane8}
                                         : {{24{w_lane8[7]}}, w_lane8};
            c_half:  w_load = r_unsigned ? {16'h0, w_lane16}
                                         : {{16{w_lane16[15]}}, w_lane16};
            default: w_load = r_word;
        endcase
    end

    assign bus.gnt         = w_gnt;
    assign bus.mem_wr_en   = w_mem_wr_en;
    assign bus.mem_wr_data = w_mem_wr_data;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.busy        = (r_state != S_IDLE) && !reset;
    assign bus.rsp_valid   = (r_state == S_DONE) && !reset;
    assign bus.rsp_id      = bus.rsp_valid && r_id;
    assign bus.rsp_err     = bus.rsp_valid && r_err;
    assign bus.rsp_rdata   = (bus.rsp_valid && !r_we && !r_err) ? w_load : '0;

endmodule
`default_nettype wire
